// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: resolves DIGIT bits per clock through a registered
// ripple carry and reports sum, carry-out and signed overflow with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C  = WIDTH / DIGIT;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_next;
  logic             msb_cin;

  always_comb begin
    digit_sum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
              + (DIGIT+1)'(carry_q);
    // New digit enters at the top so after C shifts the LSB digit sits at bit 0.
    res_next  = (res_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Carry into the top column recovered from its sum bit and operand bits.
    msb_cin   = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ digit_sum[DIGIT-1];
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> DIGIT;
      b_sh_d  = b_sh_q >> DIGIT;
      res_d   = res_next;
      carry_d = digit_sum[DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        state_d = DONE;
        sum_d   = res_next;
        cout_d  = digit_sum[DIGIT];
        ovf_d   = msb_cin ^ digit_sum[DIGIT];
      end
    end else if (start) begin
      // Subtract is a + ~b + 1, so cin is replaced by the forced carry.
      state_d = RUN;
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      carry_d = sub | cin;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift registers are reset too, so an abandoned operation leaves nothing behind.
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit single-slice ops, handshake and reset cases,
// plus all 4-bit operand/mode combinations for DIGIT = 1, 2 and 4.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, one bit per cycle
  logic       start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // 4-bit instances sharing one stimulus
  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] busy4, done4, cout4, ovf4;
  logic [3:0] sum4 [3];

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4_d1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]), .cout(cout4[0]), .ovf(ovf4[0])
  );
  serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4_d2 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]), .cout(cout4[1]), .ovf(ovf4[1])
  );
  serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut4_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]), .cout(cout4[2]), .ovf(ovf4[2])
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op8(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                         input logic ci, input logic si, input logic [7:0] es,
                         input logic ec, input logic eo);
    int cyc;
    a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd8);
    check({tag, " result"}, 32'({done, busy, cout, ovf, sum}), 32'({1'b1, 1'b0, ec, eo, es}));
    @(negedge clk);
    check({tag, " pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, gap, ndone;
    int ck [3];
    logic [2:0] seen;
    logic [3:0] bb;
    logic       cc;
    logic [4:0] full;
    logic       eovf;

    ck[0] = 4; ck[1] = 2; ck[2] = 1;

    // Reset values
    @(negedge clk);
    check("reset outs", 32'({busy, done, cout, ovf, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed add/sub vectors
    run_op8("add 5a+33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op8("add ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op8("add 7f+00+1", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op8("sub 10-20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op8("sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start during RUN is ignored
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (20) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("ignore done count", 32'(ndone), 32'd1);
    check("ignore result", 32'({cout, ovf, sum}), 32'({1'b0, 1'b0, 8'h46}));

    // Back-to-back accept in DONE
    a = 8'h5A; b = 8'h33; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b first", 32'({done, cout, ovf, sum}), 32'({1'b1, 1'b0, 1'b1, 8'h8D}));
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted", 32'({busy, done}), 32'({1'b1, 1'b0}));
    gap = 1;
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b gap", 32'(gap), 32'd9);
    check("b2b second", 32'({done, cout, ovf, sum}), 32'({1'b1, 1'b0, 1'b0, 8'h03}));
    @(negedge clk);

    // Reset in the middle of RUN
    a = 8'h5A; b = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid reset outs", 32'({busy, done, cout, ovf, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after reset", 32'(ndone), 32'd0);
    run_op8("post reset", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // All 4-bit combinations on DIGIT = 1, 2, 4
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int ia = 0; ia < 16; ia++) begin
          for (int ib = 0; ib < 16; ib++) begin
            a4 = 4'(ia); b4 = 4'(ib); cin4 = c[0]; sub4 = s[0];
            bb   = s[0] ? ~4'(ib) : 4'(ib);
            cc   = s[0] ? 1'b1 : c[0];
            full = {1'b0, 4'(ia)} + {1'b0, bb} + {4'b0, cc};
            eovf = (a4[3] == bb[3]) && (full[3] != a4[3]);
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            cyc  = 0;
            seen = '0;
            while (seen != 3'b111 && cyc < 12) begin
              @(negedge clk);
              cyc++;
              for (int k = 0; k < 3; k++) begin
                if (done4[k] && !seen[k]) begin
                  seen[k] = 1'b1;
                  check($sformatf("w4 d%0d s%0d c%0d %0h,%0h", 4 / ck[k], s, c, ia, ib),
                        32'({8'(cyc), cout4[k], ovf4[k], sum4[k]}),
                        32'({8'(ck[k]), full[4], eovf, full[3:0]}));
                end
              end
            end
            if (seen != 3'b111)
              check($sformatf("w4 timeout %0h,%0h", ia, ib), 32'(seen), 32'd7);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
